ioctl_ldr_bridge: RTL

//  Decouples the HPS ioctl download byte stream from the X68K_top loader port (ldr_*).

---
 rtl/x68k_ldr_pkg.sv | 19 +
 rtl/ldr_byte_fifo.sv | 52 +++++
 rtl/ioctl_ldr_bridge.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/x68k_ldr_pkg.sv
// Shared types for the ioctl-to-loader bridge: FSM states and the FIFO entry payload.
package x68k_ldr_pkg;

    localparam int unsigned LDR_AW_DEF = 20;
    localparam int unsigned DATA_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ldr_state_e;

    typedef struct packed {
        logic [LDR_AW_DEF-1:0] addr;
        logic [DATA_W-1:0]     data;
    } ldr_entry_t;

endpackage

// File: rtl/ldr_byte_fifo.sv
// Small synchronous FIFO of {addr,data} loader entries with occupancy count.
// Head entry is presented combinationally; caller never pops empty or pushes full.
module ldr_byte_fifo
    import x68k_ldr_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  ldr_entry_t               wdata,
    output ldr_entry_t               head_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    ldr_entry_t        mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    // Pointer and occupancy tracking; flush on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign head_c  = mem[rd_ptr];
    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == CW'(0));

endmodule

// File: rtl/ioctl_ldr_bridge.sv
// Bridge from the hps_io ioctl download stream to the X68K_top loader port.
// Buffers bytes in a FIFO, replays them over the ldr_wr/ldr_ack handshake,
// back-pressures hps_io with ioctl_wait and flags load completion.
// Optional: define LDR_CHECKSUM_EN to build the 16-bit byte checksum on ldr_sum.
module ioctl_ldr_bridge
    import x68k_ldr_pkg::*;
#(
    parameter int unsigned LDR_AW   = LDR_AW_DEF,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned HEADROOM = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [LDR_AW-1:0] ldr_addr,
    output logic [7:0]        ldr_wdat,
    output logic              ldr_aen,
    output logic              ldr_wr,
    input  logic              ldr_ack,
    output logic              ldr_done,
    output logic              ldr_ovf,
    output logic [15:0]       ldr_sum
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    ldr_state_e      state;
    ldr_state_e      state_next;
    logic            old_download;
    logic            old_ack;
    logic            armed;
    logic            dl_rise;
    logic            dl_fall;
    logic            ack_rise;
    logic            in_range;
    logic            push;
    logic            pop;
    logic            drop;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    ldr_entry_t      push_entry;
    ldr_entry_t      head;

    // A session already in progress at reset release is not a rise: armed
    // only once download has been seen low after reset.
    assign dl_rise  = armed & ~old_download & ioctl_download;
    assign dl_fall  = old_download & ~ioctl_download;
    assign ack_rise = ~old_ack & ldr_ack & ldr_wr;
    assign in_range = ((ioctl_addr >> LDR_AW) == 25'd0);

    assign push_entry.addr = LDR_AW_DEF'(ioctl_addr[LDR_AW-1:0]);
    assign push_entry.data = ioctl_dout;

    ldr_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk_sys),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wdata   (push_entry),
        .head_c  (head),
        .full_c  (full),
        .empty_c (empty),
        .count   (count)
    );

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state, FIFO push/pop and drop decisions.
    always_comb begin
        state_next = state;
        push       = 1'b0;
        pop        = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                if (dl_rise && !ldr_done) state_next = LOAD;
            end
            LOAD: begin
                if (dl_fall) state_next = DRAIN;
                if (ioctl_wr) begin
                    push = in_range & ~full;
                    drop = ~in_range | full;
                end
                pop = ~ldr_wr & ~empty;
            end
            DRAIN: begin
                pop = ~ldr_wr & ~empty;
                if (empty && !ldr_wr) state_next = DONE;
            end
            DONE: begin
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered loader-side outputs, edge detectors and flags.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            old_download <= 1'b0;
            old_ack      <= 1'b0;
            armed        <= 1'b0;
            ioctl_wait   <= 1'b0;
            ldr_addr     <= '0;
            ldr_wdat     <= '0;
            ldr_aen      <= 1'b0;
            ldr_wr       <= 1'b0;
            ldr_done     <= 1'b0;
            ldr_ovf      <= 1'b0;
        end else begin
            old_download <= ioctl_download;
            old_ack      <= ldr_ack;
            armed        <= armed | ~ioctl_download;
            ioctl_wait   <= (count >= CW'(DEPTH - HEADROOM));
            ldr_aen      <= (state_next == LOAD) || (state_next == DRAIN);
            if (drop) ldr_ovf <= 1'b1;
            if (state == DRAIN && state_next == DONE) ldr_done <= 1'b1;
            if (pop) begin
                ldr_addr <= LDR_AW'(head.addr);
                ldr_wdat <= head.data;
                ldr_wr   <= 1'b1;
            end else if (ack_rise) begin
                ldr_wr   <= 1'b0;
            end
        end
    end

`ifdef LDR_CHECKSUM_EN
    logic [15:0] sum;

    // Running sum of issued bytes; restarts on each load session.
    always_ff @(posedge clk_sys) begin
        if (reset)                                   sum <= 16'd0;
        else if (state == IDLE && state_next == LOAD) sum <= 16'd0;
        else if (pop)                                sum <= sum + 16'(head.data);
    end

    assign ldr_sum = sum;
`else
    assign ldr_sum = 16'd0;
`endif

endmodule
